// File: rtl/fetch_if.sv
// Fetch-stage bus: decode/execute redirects, instruction memory port and the IF/ID register outputs.
interface fetch_if;
   logic        i_hold;
   logic        i_inst_busy;
   logic        i_data_busy;
   logic        i_dec_vld;
   logic [31:0] i_dec_pc;
   logic        i_jal;
   logic        i_jalr;
   logic [31:0] i_immediate;
   logic [31:0] i_jalr_rs1;
   logic        i_br_taken;
   logic [31:0] i_br_target;
   logic [31:0] o_imem_raddr;
   logic [31:0] i_imem_rdata;
   logic [31:0] o_pc;
   logic [31:0] o_nxt_pc;
   logic [31:0] o_inst;
   logic        o_vld;
   logic        o_flush;

   modport slave (
      input  i_hold, i_inst_busy, i_data_busy, i_dec_vld, i_dec_pc, i_jal, i_jalr,
             i_immediate, i_jalr_rs1, i_br_taken, i_br_target, i_imem_rdata,
      output o_imem_raddr, o_pc, o_nxt_pc, o_inst, o_vld, o_flush
   );

   modport master (
      output i_hold, i_inst_busy, i_data_busy, i_dec_vld, i_dec_pc, i_jal, i_jalr,
             i_immediate, i_jalr_rs1, i_br_taken, i_br_target, i_imem_rdata,
      input  o_imem_raddr, o_pc, o_nxt_pc, o_inst, o_vld, o_flush
   );
endinterface

// File: rtl/fetch.sv
// RV32I instruction-fetch stage: PC, imem address, IF/ID register and a pending-redirect FSM
// that keeps redirects arriving during an instruction-cache miss from being lost.
module fetch #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic    i_clk,
   input  logic    i_rst,
   fetch_if.slave  bus
);
   typedef enum logic [1:0] {RUN, MISS, PEND} state_t;
   localparam logic [31:0] NOP = 32'h0000_0033;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_nxt_q, ifid_nxt_d;
   logic [31:0] ifid_inst_q, ifid_inst_d;
   logic        ifid_vld_q, ifid_vld_d;

   logic        stall, br_ok, jmp_ok, redir;
   logic [31:0] tgt, pc_plus4;

   assign stall    = bus.i_hold | bus.i_data_busy | bus.i_inst_busy;
   assign pc_plus4 = pc_q + 32'd4;

   // Jumps need decode to advance (no hold); a taken branch always wins.
   always_comb begin
      br_ok  = bus.i_br_taken & ~bus.i_data_busy;
      jmp_ok = bus.i_dec_vld & ~bus.i_hold & ~bus.i_data_busy;
      redir  = 1'b0;
      tgt    = pc_plus4;
      if (br_ok) begin
         redir = 1'b1;
         tgt   = bus.i_br_target;
      end else if (jmp_ok && bus.i_jalr) begin
         redir = 1'b1;
         tgt   = (bus.i_jalr_rs1 + bus.i_immediate) & ~32'h1;
      end else if (jmp_ok && bus.i_jal) begin
         redir = 1'b1;
         tgt   = bus.i_dec_pc + bus.i_immediate;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_d      = pend_q;
      ifid_pc_d   = ifid_pc_q;
      ifid_nxt_d  = ifid_nxt_q;
      ifid_inst_d = ifid_inst_q;
      ifid_vld_d  = ifid_vld_q;
      if (!bus.i_data_busy) begin
         unique case (state_q)
            RUN: begin
               if (redir) begin
                  ifid_vld_d  = 1'b0;
                  ifid_inst_d = NOP;
                  if (bus.i_inst_busy) begin
                     pend_d  = tgt;
                     state_d = PEND;
                  end else begin
                     pc_d = tgt;
                  end
               end else if (bus.i_inst_busy) begin
                  if (!bus.i_hold) begin
                     ifid_vld_d  = 1'b0;
                     ifid_inst_d = NOP;
                  end
                  state_d = MISS;
               end else if (!stall) begin
                  pc_d        = pc_plus4;
                  ifid_pc_d   = pc_q;
                  ifid_nxt_d  = pc_plus4;
                  ifid_inst_d = bus.i_imem_rdata;
                  ifid_vld_d  = 1'b1;
               end
            end
            MISS: begin
               if (redir) begin
                  pend_d      = tgt;
                  state_d     = PEND;
                  ifid_vld_d  = 1'b0;
                  ifid_inst_d = NOP;
               end else if (!bus.i_inst_busy) begin
                  state_d = RUN;
                  if (!bus.i_hold) begin
                     pc_d        = pc_plus4;
                     ifid_pc_d   = pc_q;
                     ifid_nxt_d  = pc_plus4;
                     ifid_inst_d = bus.i_imem_rdata;
                     ifid_vld_d  = 1'b1;
                  end
               end else if (!bus.i_hold) begin
                  ifid_vld_d  = 1'b0;
                  ifid_inst_d = NOP;
               end
            end
            PEND: begin
               // The word returning for the old path is dropped; only the pending target survives.
               if (redir || !bus.i_hold) begin
                  ifid_vld_d  = 1'b0;
                  ifid_inst_d = NOP;
               end
               if (redir) pend_d = tgt;
               if (!bus.i_inst_busy) begin
                  pc_d    = redir ? tgt : pend_q;
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= RUN;
         pc_q        <= RESET_ADDR;
         pend_q      <= 32'h0;
         ifid_pc_q   <= RESET_ADDR;
         ifid_nxt_q  <= RESET_ADDR + 32'd4;
         ifid_inst_q <= NOP;
         ifid_vld_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_q      <= pend_d;
         ifid_pc_q   <= ifid_pc_d;
         ifid_nxt_q  <= ifid_nxt_d;
         ifid_inst_q <= ifid_inst_d;
         ifid_vld_q  <= ifid_vld_d;
      end
   end

   assign bus.o_imem_raddr = pc_q;
   assign bus.o_pc         = ifid_pc_q;
   assign bus.o_nxt_pc     = ifid_nxt_q;
   assign bus.o_inst       = ifid_inst_q;
   assign bus.o_vld        = ifid_vld_q;
   assign bus.o_flush      = bus.i_br_taken & ~bus.i_data_busy & ~i_rst;
endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: scoreboard of expected instructions consumed by decode plus per-scenario direct checks.
module tb_fetch;
   logic clk = 1'b0;
   logic rst;
   bit   uniform;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_e;

   always #5 clk = ~clk;

   fetch_if bus();
   fetch #(.RESET_ADDR(32'h0000_0000)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   function automatic logic [31:0] imem(input logic [31:0] a, input bit u);
      return u ? 32'h0000_0013 : ((a << 7) | 32'h0000_0013);
   endfunction

   assign bus.i_imem_rdata = imem(bus.o_imem_raddr, uniform);

   // Decode consumes IF/ID whenever it is valid and neither held nor frozen.
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.o_vld === 1'b1 && bus.i_hold === 1'b0 && bus.i_data_busy === 1'b0) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got o_pc=%h, required no valid instruction", bus.o_pc);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.o_pc !== mon_e || bus.o_nxt_pc !== mon_e + 32'd4 || bus.o_inst !== imem(mon_e, uniform)) begin
               n_fail++;
               $display("FAIL sb_ifid: got pc=%h nxt=%h inst=%h, required pc=%h nxt=%h inst=%h",
                        bus.o_pc, bus.o_nxt_pc, bus.o_inst, mon_e, mon_e + 32'd4, imem(mon_e, uniform));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_hold      = 1'b0;
      bus.i_inst_busy = 1'b0;
      bus.i_data_busy = 1'b0;
      bus.i_dec_vld   = 1'b0;
      bus.i_dec_pc    = 32'h0;
      bus.i_jal       = 1'b0;
      bus.i_jalr      = 1'b0;
      bus.i_immediate = 32'h0;
      bus.i_jalr_rs1  = 32'h0;
      bus.i_br_taken  = 1'b0;
      bus.i_br_target = 32'h0;
   endtask

   // Leaves rst asserted; the caller releases it right after the reset edge.
   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d instructions never seen, required 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      uniform = 1'b1;
      do_reset();
      bus.i_br_taken  = 1'b1;
      bus.i_br_target = 32'h400;
      #1;
      n_chk++;
      if (bus.o_flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b required 0", bus.o_flush); end
      n_chk++;
      if (bus.o_imem_raddr !== 32'h0 || bus.o_pc !== 32'h0 || bus.o_nxt_pc !== 32'h4) begin
         n_fail++;
         $display("FAIL rst_pc: got raddr=%h pc=%h nxt=%h required 0/0/4", bus.o_imem_raddr, bus.o_pc, bus.o_nxt_pc);
      end
      n_chk++;
      if (bus.o_inst !== 32'h33 || bus.o_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ifid: got inst=%h vld=%b required 00000033/0", bus.o_inst, bus.o_vld);
      end
      bus.i_br_taken = 1'b0;
      for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_chk++;
         if (bus.o_pc !== 32'(i * 4) || bus.o_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_pc: got pc=%h vld=%b required %h/1", bus.o_pc, bus.o_vld, 32'(i * 4));
         end
      end
      step();
      rst = 1'b1;
      uniform = 1'b0;
   endtask

   task automatic test_miss();
      do_reset();
      foreach (exp_q[i]) exp_q.delete(i);
      for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
      rst = 1'b0;
      repeat (4) step();
      bus.i_inst_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_chk++;
         if (bus.o_imem_raddr !== 32'h10 || bus.o_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_hold: got raddr=%h vld=%b required 00000010/0", bus.o_imem_raddr, bus.o_vld);
         end
      end
      bus.i_inst_busy = 1'b0;
      step();
      n_chk++;
      if (bus.o_pc !== 32'h10 || bus.o_vld !== 1'b1 || bus.o_imem_raddr !== 32'h14) begin
         n_fail++;
         $display("FAIL miss_capture: got pc=%h vld=%b raddr=%h required 10/1/14", bus.o_pc, bus.o_vld, bus.o_imem_raddr);
      end
      step();
      rst = 1'b1;
   endtask

   task automatic test_jump();
      do_reset();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h120);
      exp_q.push_back(32'h300);
      rst = 1'b0;
      repeat (2) step();
      bus.i_dec_vld   = 1'b1;
      bus.i_jal       = 1'b1;
      bus.i_dec_pc    = 32'h20;
      bus.i_immediate = 32'h100;
      #1;
      n_chk++;
      if (bus.o_flush !== 1'b0) begin n_fail++; $display("FAIL jal_flush: got %b required 0", bus.o_flush); end
      step();
      idle_inputs();
      n_chk++;
      if (bus.o_imem_raddr !== 32'h120 || bus.o_vld !== 1'b0 || bus.o_inst !== 32'h33 || bus.o_pc !== 32'h4) begin
         n_fail++;
         $display("FAIL jal_bubble: got raddr=%h vld=%b inst=%h pc=%h required 120/0/33/4",
                  bus.o_imem_raddr, bus.o_vld, bus.o_inst, bus.o_pc);
      end
      step();
      bus.i_dec_vld   = 1'b1;
      bus.i_jalr      = 1'b1;
      bus.i_jalr_rs1  = 32'h201;
      bus.i_immediate = 32'h100;
      step();
      idle_inputs();
      n_chk++;
      if (bus.o_imem_raddr !== 32'h300 || bus.o_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL jalr_target: got raddr=%h vld=%b required 300/0", bus.o_imem_raddr, bus.o_vld);
      end
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic test_branch();
      do_reset();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h400);
      rst = 1'b0;
      repeat (2) step();
      bus.i_br_taken  = 1'b1;
      bus.i_br_target = 32'h400;
      bus.i_dec_vld   = 1'b1;
      bus.i_jalr      = 1'b1;
      bus.i_jalr_rs1  = 32'h1000;
      bus.i_immediate = 32'h5;
      #1;
      n_chk++;
      if (bus.o_flush !== 1'b1) begin n_fail++; $display("FAIL br_flush: got %b required 1", bus.o_flush); end
      step();
      idle_inputs();
      #1;
      n_chk++;
      if (bus.o_imem_raddr !== 32'h400 || bus.o_vld !== 1'b0 || bus.o_flush !== 1'b0) begin
         n_fail++;
         $display("FAIL br_redirect: got raddr=%h vld=%b flush=%b required 400/0/0",
                  bus.o_imem_raddr, bus.o_vld, bus.o_flush);
      end
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic test_pend();
      do_reset();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h80);
      rst = 1'b0;
      repeat (2) step();
      bus.i_inst_busy = 1'b1;
      step();
      bus.i_br_taken  = 1'b1;
      bus.i_br_target = 32'h80;
      step();
      bus.i_br_taken = 1'b0;
      n_chk++;
      if (bus.o_imem_raddr !== 32'h8 || bus.o_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL pend_wait: got raddr=%h vld=%b required 8/0", bus.o_imem_raddr, bus.o_vld);
      end
      step();
      bus.i_inst_busy = 1'b0;
      step();
      n_chk++;
      if (bus.o_imem_raddr !== 32'h80 || bus.o_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL pend_resume: got raddr=%h vld=%b required 80/0", bus.o_imem_raddr, bus.o_vld);
      end
      step();
      n_chk++;
      if (bus.o_pc !== 32'h80 || bus.o_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL pend_first: got pc=%h vld=%b required 80/1", bus.o_pc, bus.o_vld);
      end
      step();
      rst = 1'b1;
   endtask

   task automatic test_hold_reset();
      do_reset();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      exp_q.push_back(32'h0);
      rst = 1'b0;
      repeat (2) step();
      bus.i_hold      = 1'b1;
      bus.i_dec_vld   = 1'b1;
      bus.i_jal       = 1'b1;
      bus.i_dec_pc    = 32'h40;
      bus.i_immediate = 32'h40;
      for (int i = 0; i < 2; i++) begin
         step();
         n_chk++;
         if (bus.o_pc !== 32'h4 || bus.o_vld !== 1'b1 || bus.o_imem_raddr !== 32'h8) begin
            n_fail++;
            $display("FAIL hold_freeze: got pc=%h vld=%b raddr=%h required 4/1/8", bus.o_pc, bus.o_vld, bus.o_imem_raddr);
         end
      end
      idle_inputs();
      step();
      bus.i_inst_busy = 1'b1;
      step();
      bus.i_br_taken  = 1'b1;
      bus.i_br_target = 32'h200;
      step();
      bus.i_br_taken = 1'b0;
      rst = 1'b1;
      step();
      n_chk++;
      if (bus.o_pc !== 32'h0 || bus.o_nxt_pc !== 32'h4 || bus.o_inst !== 32'h33 ||
          bus.o_vld !== 1'b0 || bus.o_imem_raddr !== 32'h0) begin
         n_fail++;
         $display("FAIL pend_reset: got pc=%h nxt=%h inst=%h vld=%b raddr=%h required 0/4/33/0/0",
                  bus.o_pc, bus.o_nxt_pc, bus.o_inst, bus.o_vld, bus.o_imem_raddr);
      end
      bus.i_inst_busy = 1'b0;
      rst = 1'b0;
      step();
      n_chk++;
      if (bus.o_pc !== 32'h0 || bus.o_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_fetch: got pc=%h vld=%b required 0/1", bus.o_pc, bus.o_vld);
      end
      step();
      rst = 1'b1;
   endtask

   task automatic test_data_busy();
      do_reset();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      rst = 1'b0;
      repeat (2) step();
      bus.i_data_busy = 1'b1;
      bus.i_br_taken  = 1'b1;
      bus.i_br_target = 32'h500;
      #1;
      n_chk++;
      if (bus.o_flush !== 1'b0) begin n_fail++; $display("FAIL dbusy_flush: got %b required 0", bus.o_flush); end
      step();
      n_chk++;
      if (bus.o_imem_raddr !== 32'h8 || bus.o_pc !== 32'h4 || bus.o_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL dbusy_freeze: got raddr=%h pc=%h vld=%b required 8/4/1", bus.o_imem_raddr, bus.o_pc, bus.o_vld);
      end
      idle_inputs();
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         n_chk++;
         if (bus.o_vld !== 1'b1 || bus.o_imem_raddr !== 32'(i * 4 + 4)) begin
            n_fail++;
            $display("FAIL b2b_rate: got vld=%b raddr=%h required 1/%h", bus.o_vld, bus.o_imem_raddr, 32'(i * 4 + 4));
         end
      end
      step();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      uniform = 1'b1;
      idle_inputs();
      test_reset();
      test_miss();
      test_jump();
      test_branch();
      test_pend();
      test_hold_reset();
      test_data_busy();
      test_back_to_back();
      do_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the five-stage RV32I pipeline: owns the program counter, drives the instruction-memory read address, and loads the IF/ID register consumed by the decode stage. It applies redirects from decode (jal/jalr) and execute (taken branch), generates the decode flush, and stalls on hazard holds and cache misses. A pending-redirect state machine keeps a redirect that arrives during an instruction-cache miss from being lost.

## Interface
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_hold  in  1  hold IF/ID (load-use hazard from decode)
- i_inst_busy  in  1  instruction cache miss in progress
- i_data_busy  in  1  data cache miss; whole pipeline frozen
- i_dec_vld  in  1  decode instruction valid
- i_dec_pc  in  32  PC of the instruction in decode
- i_jal  in  1  decode holds jal
- i_jalr  in  1  decode holds jalr
- i_immediate  in  32  decode immediate
- i_jalr_rs1  in  32  forwarded rs1 for jalr
- i_br_taken  in  1  execute resolved a taken branch
- i_br_target  in  32  branch target from execute
- o_imem_raddr  out  32  instruction memory address
- i_imem_rdata  in  32  instruction word, valid when !i_inst_busy
- o_pc  out  32  IF/ID PC
- o_nxt_pc  out  32  IF/ID PC+4
- o_inst  out  32  IF/ID instruction
- o_vld  out  1  IF/ID valid
- o_flush  out  1  flush decode (one cycle)

## Operation
- pc_q: 32-bit register; o_imem_raddr = pc_q combinationally.
- stall = i_hold | i_data_busy | i_inst_busy.
- Redirect, evaluated only when !i_data_busy, priority: (1) i_br_taken -> i_br_target; (2) i_dec_vld & i_jalr & !i_hold -> (i_jalr_rs1 + i_immediate) & ~32'h1; (3) i_dec_vld & i_jal & !i_hold -> i_dec_pc + i_immediate. Adds are 32-bit modulo 2^32.
- o_flush = 1 in the cycle a branch redirect (1) is accepted; 0 for jal/jalr (decode instruction is the jump itself and is kept).
- States RUN, MISS, PEND; reset -> RUN.
- RUN: redirect & !i_inst_busy -> pc_q <= target, IF/ID <= bubble, stay RUN. Redirect & i_inst_busy -> pend_q <= target, IF/ID <= bubble, -> PEND. No redirect & i_inst_busy -> IF/ID <= bubble (unless i_hold), -> MISS. No redirect & !stall -> pc_q <= pc_q+4, IF/ID <= {pc_q, pc_q+4, i_imem_rdata, 1}. i_hold or i_data_busy alone -> pc_q and IF/ID hold.
- MISS: redirect -> pend_q <= target, -> PEND. i_inst_busy falls -> return RUN; fetched word captured on that cycle (if !i_hold & !i_data_busy).
- PEND: further redirect overwrites pend_q (branch wins over jal/jalr). i_inst_busy low -> fetched word discarded, pc_q <= pend_q, IF/ID bubble, -> RUN.
- Bubble: o_vld=0, o_inst=32'h0000_0033, o_pc/o_nxt_pc unchanged.
- i_data_busy freezes pc_q, pend_q, state and IF/ID regardless of other inputs.

## Timing
- Reset values: pc_q=RESET_ADDR, o_imem_raddr=RESET_ADDR, o_pc=RESET_ADDR, o_nxt_pc=RESET_ADDR+4, o_inst=32'h0000_0033, o_vld=0, o_flush=0, state RUN, pend_q=0. Reset mid-miss or mid-PEND discards everything.
- Fetch latency: address presented cycle N, IF/ID valid cycle N+1.
- Redirect penalty: jal/jalr one bubble; taken branch two (IF/ID bubble plus o_flush to decode).
- o_flush combinational from i_br_taken & !i_data_busy; never high during reset.
- Simultaneous i_br_taken and i_jal/i_jalr: branch target used, jump ignored.
- Throughput one instruction per cycle with no stalls.

## Test plan
- Reset RESET_ADDR=0, imem returns 32'h0000_0013 everywhere, no stalls -> o_pc 0,4,8,12 on consecutive cycles, o_vld=1 from cycle 2.
- i_inst_busy high 5 cycles at PC 0x10 -> o_imem_raddr stays 0x10, o_vld=0 throughout, word captured with o_pc=0x10 the cycle busy falls.
- jal in decode at i_dec_pc=0x20, imm=0x100 -> next o_imem_raddr=0x120, one bubble, o_flush=0.
- i_br_taken with target 0x400 concurrent with i_jalr -> o_imem_raddr=0x400, o_flush=1 one cycle, IF/ID bubble.
- Branch to 0x80 during 3-cycle miss -> state PEND, stale word discarded, next address 0x80, no instruction from old path reaches o_vld=1.
- i_hold 2 cycles then i_rst asserted in PEND -> holds respected; after reset o_pc=RESET_ADDR, o_vld=0, o_inst=32'h0000_0033.
